// File: rtl/playfield_pkg.sv
// Shared constants, register map and command payload for the playfield writer.
package playfield_pkg;

  localparam int unsigned CPU_W      = 12;
  localparam int unsigned PF_ADDR_W  = 10;
  localparam int unsigned PF_DATA_W  = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PF_CELLS   = 1024;

  localparam logic [1:0] IO_SPACE = 2'h3;
  localparam logic [1:0] REG_ADDR = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_FILL = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam int unsigned STAT_CNT_LSB   = 0;
  localparam int unsigned STAT_FULL      = 4;
  localparam int unsigned STAT_OVF       = 5;
  localparam int unsigned STAT_FILL_PEND = 6;
  localparam int unsigned STAT_BUSY      = 7;

  typedef struct packed {
    logic [PF_ADDR_W-1:0] addr;
    logic [PF_DATA_W-1:0] data;
  } pf_cmd_t;

  // True when a CPU address falls in the I/O window.
  function automatic logic is_io(input logic [CPU_W-1:0] addr);
    return addr[CPU_W-1 -: 2] == IO_SPACE;
  endfunction

endpackage

// File: rtl/pf_cmd_fifo.sv
// Small synchronous command FIFO; head entry is visible without a pop.
module pf_cmd_fifo
  import playfield_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                     i_Clk,
  input  logic                     reset,
  input  logic                     push,
  input  pf_cmd_t                  push_cmd,
  input  logic                     pop,
  output pf_cmd_t                  head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  pf_cmd_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;
  logic [CW-1:0]    count_d;

  // A full FIFO rejects a push even when a pop happens in the same cycle.
  always_comb begin
    push_ok_c = push && !full;
    pop_ok_c  = pop && !empty;
    count_d   = count + CW'(push_ok_c) - CW'(pop_ok_c);
  end

  assign head_c = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge i_Clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_cmd;
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/playfield_writer.sv
// CPU-side playfield RAM writer: register decode, command FIFO, fill engine.
module playfield_writer
  import playfield_pkg::*;
(
  input  logic                 i_Clk,
  input  logic                 reset,
  input  logic                 cpu_write,
  input  logic [CPU_W-1:0]     cpu_addr,
  input  logic [CPU_W-1:0]     cpu_wr_data,
  output logic [CPU_W-1:0]     cpu_rd_data,
  output logic                 pf_write,
  output logic [PF_ADDR_W-1:0] pf_write_addr,
  output logic [PF_DATA_W-1:0] pf_wr_data,
  output logic                 busy
);

  logic                 wr_addr_c, wr_data_c, wr_fill_c, wr_ctrl_c, ctrl_sel_c;
  logic                 unused_bits_c;

  logic [0:0]           state_q, state_d;
  logic [PF_ADDR_W-1:0] fill_ctr_q, fill_ctr_d;
  logic [PF_DATA_W-1:0] fill_val_q, fill_val_d;
  logic                 fill_pend_q, fill_pend_d;
  logic [CNT_W-1:0]     barrier_q, barrier_d;
  logic                 ovf_q, ovf_d;
  logic [PF_ADDR_W-1:0] ptr_q, ptr_d;
  logic                 pf_write_d;
  logic [PF_ADDR_W-1:0] pf_addr_d;
  logic [PF_DATA_W-1:0] pf_data_d;
  logic                 busy_d;
  logic [CNT_W-1:0]     count_d;

  pf_cmd_t              push_cmd_c;
  pf_cmd_t              head_c;
  logic                 fifo_pop_c;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  // Register write strobes; only the I/O window is decoded.
  always_comb begin
    wr_addr_c  = cpu_write && is_io(cpu_addr) && (cpu_addr[1:0] == REG_ADDR);
    wr_data_c  = cpu_write && is_io(cpu_addr) && (cpu_addr[1:0] == REG_DATA);
    wr_fill_c  = cpu_write && is_io(cpu_addr) && (cpu_addr[1:0] == REG_FILL);
    wr_ctrl_c  = cpu_write && is_io(cpu_addr) && (cpu_addr[1:0] == REG_CTRL);
    ctrl_sel_c = is_io(cpu_addr) && (cpu_addr[1:0] == REG_CTRL);
    push_cmd_c = '{addr: ptr_q, data: PF_DATA_W'(cpu_wr_data)};
  end

  assign unused_bits_c = ^{cpu_addr[9:2], cpu_wr_data[CPU_W-1:PF_ADDR_W]};

  pf_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clk    (i_Clk),
    .reset    (reset),
    .push     (wr_data_c),
    .push_cmd (push_cmd_c),
    .pop      (fifo_pop_c),
    .head_c   (head_c),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Next-state: FSM drains the FIFO or sweeps a fill; CPU writes update pointer/flags.
  // barrier counts FIFO entries queued ahead of a pending fill so later DATA waits.
  always_comb begin
    state_d     = state_q;
    fill_ctr_d  = fill_ctr_q;
    fill_val_d  = fill_val_q;
    fill_pend_d = fill_pend_q;
    barrier_d   = barrier_q;
    ovf_d       = ovf_q;
    ptr_d       = ptr_q;
    pf_write_d  = 1'b0;
    pf_addr_d   = pf_write_addr;
    pf_data_d   = pf_wr_data;
    fifo_pop_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fill_pend_q && (barrier_q == '0)) begin
          state_d     = ST_FILL;
          fill_ctr_d  = '0;
          fill_pend_d = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          pf_write_d = 1'b1;
          pf_addr_d  = head_c.addr;
          pf_data_d  = head_c.data;
          if (fill_pend_q) barrier_d = barrier_q - CNT_W'(1);
        end
      end
      ST_FILL: begin
        pf_write_d = 1'b1;
        pf_addr_d  = fill_ctr_q;
        pf_data_d  = fill_val_q;
        fill_ctr_d = fill_ctr_q + PF_ADDR_W'(1);
        if (fill_ctr_q == PF_ADDR_W'(PF_CELLS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_addr_c) ptr_d = PF_ADDR_W'(cpu_wr_data);
    if (wr_data_c) begin
      ptr_d = ptr_q + PF_ADDR_W'(1);
      if (fifo_full) ovf_d = 1'b1;
    end
    if (wr_fill_c) begin
      if (fill_pend_q || (state_q == ST_FILL)) begin
        ovf_d = 1'b1;
      end else begin
        fill_val_d  = PF_DATA_W'(cpu_wr_data);
        fill_pend_d = 1'b1;
        barrier_d   = fifo_count - CNT_W'(fifo_pop_c);
      end
    end
    if (wr_ctrl_c && cpu_wr_data[0]) ovf_d = 1'b0;

    count_d = fifo_count + CNT_W'(wr_data_c && !fifo_full) - CNT_W'(fifo_pop_c);
    busy_d  = (count_d != '0) || fill_pend_d || (state_d == ST_FILL) || pf_write_d;
  end

  // State, flags and registered playfield outputs.
  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fill_ctr_q    <= '0;
      fill_val_q    <= '0;
      fill_pend_q   <= 1'b0;
      barrier_q     <= '0;
      ovf_q         <= 1'b0;
      ptr_q         <= '0;
      pf_write      <= 1'b0;
      pf_write_addr <= '0;
      pf_wr_data    <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_ctr_q    <= fill_ctr_d;
      fill_val_q    <= fill_val_d;
      fill_pend_q   <= fill_pend_d;
      barrier_q     <= barrier_d;
      ovf_q         <= ovf_d;
      ptr_q         <= ptr_d;
      pf_write      <= pf_write_d;
      pf_write_addr <= pf_addr_d;
      pf_wr_data    <= pf_data_d;
      busy          <= busy_d;
    end
  end

  // Status word, visible only while the CTRL register is addressed.
  always_comb begin
    cpu_rd_data = '0;
    if (ctrl_sel_c) begin
      cpu_rd_data[STAT_BUSY]           = busy;
      cpu_rd_data[STAT_FILL_PEND]      = fill_pend_q;
      cpu_rd_data[STAT_OVF]            = ovf_q;
      cpu_rd_data[STAT_FULL]           = fifo_full;
      cpu_rd_data[STAT_CNT_LSB +: 3]   = 3'(fifo_count);
    end
  end

endmodule

// File: tb/tb_playfield_writer.sv
// Self-checking bench for playfield_writer against a write-stream reference model.
module tb_playfield_writer;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic        i_Clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_write;
  logic [11:0] cpu_addr;
  logic [11:0] cpu_wr_data;
  logic [11:0] cpu_rd_data;
  logic        pf_write;
  logic [9:0]  pf_write_addr;
  logic [7:0]  pf_wr_data;
  logic        busy;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_wr_cyc = 0;
  int  m_ptr = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];

  playfield_writer dut (
    .i_Clk         (i_Clk),
    .reset         (reset),
    .cpu_write     (cpu_write),
    .cpu_addr      (cpu_addr),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_rd_data   (cpu_rd_data),
    .pf_write      (pf_write),
    .pf_write_addr (pf_write_addr),
    .pf_wr_data    (pf_wr_data),
    .busy          (busy)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Record every playfield write with the cycle it was visible.
  always @(negedge i_Clk) begin
    if (pf_write === 1'b1) begin
      obs_q.push_back('{int'(pf_write_addr), int'(pf_wr_data), cyc});
      last_wr_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [1:0] r, input int d);
    cpu_write   = 1'b1;
    cpu_addr    = {2'b11, 8'h00, r};
    cpu_wr_data = 12'(d);
  endtask

  task automatic cpu_wr(input logic [1:0] r, input int d);
    @(negedge i_Clk);
    drive(r, d);
  endtask

  task automatic cpu_idle();
    @(negedge i_Clk);
    cpu_write   = 1'b0;
    cpu_addr    = 12'hC03;
    cpu_wr_data = 12'h000;
  endtask

  // Model: a DATA write lands at the pointer, which then wraps around 1024 cells.
  task automatic exp_data(input int d, input int due);
    exp_q.push_back('{m_ptr, d % 256, due});
    m_ptr = (m_ptr + 1) % 1024;
  endtask

  task automatic exp_fill(input int start, input int v);
    for (int i = 0; i < 1024; i++) exp_q.push_back('{i, v % 256, start + i});
  endtask

  function automatic int stream_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data ||
          obs_q[i].cyc != exp_q[i].cyc) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic string diff_text(input int i);
    string s;
    if (i < obs_q.size())
      s = $sformatf("got addr=%03h data=%02h cyc=%0d", obs_q[i].addr, obs_q[i].data, obs_q[i].cyc);
    else
      s = "got no write";
    if (i < exp_q.size())
      s = {s, $sformatf(", required addr=%03h data=%02h cyc=%0d", exp_q[i].addr, exp_q[i].data, exp_q[i].cyc)};
    else
      s = {s, ", required no write"};
    return $sformatf("entry %0d: %s (writes got %0d required %0d)", i, s, obs_q.size(), exp_q.size());
  endfunction

  task automatic wait_quiet(input string name, output int fall);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge i_Clk);
      n++;
    end
    fall = cyc;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s quiet: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic wait_write_at(input int a, input string name, output int at);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    at = 0;
    while (!ok && n < 3000) begin
      @(negedge i_Clk);
      n++;
      if (pf_write === 1'b1 && int'(pf_write_addr) == a) begin
        ok = 1;
        at = cyc;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s wait: no write to addr %03h within %0d cycles", name, a, n);
    end
  endtask

  task automatic test_reset();
    cpu_write = 1'b0; cpu_addr = 12'hC03; cpu_wr_data = 12'h000;
    #1 reset = 1'b1;
    repeat (3) @(negedge i_Clk);
    checks++; if (pf_write !== 1'b0) begin failures++; $display("FAIL reset pf_write: got %b required 0", pf_write); end
    checks++; if (pf_write_addr !== 10'h000) begin failures++; $display("FAIL reset addr: got %03h required 000", pf_write_addr); end
    checks++; if (pf_wr_data !== 8'h00) begin failures++; $display("FAIL reset data: got %02h required 00", pf_wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b required 0", busy); end
    checks++; if (cpu_rd_data !== 12'h000) begin failures++; $display("FAIL reset status: got %03h required 000", cpu_rd_data); end
    @(negedge i_Clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_single_write();
    int d, fall;
    obs_q.delete(); exp_q.delete();
    cpu_wr(2'd0, 12'h005); m_ptr = 5;
    cpu_wr(2'd1, 12'h02A); exp_data(12'h02A, cyc + 2);
    cpu_idle();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single busy_rise: got %b required 1", busy); end
    checks++; if (pf_write !== 1'b0) begin failures++; $display("FAIL single latency: pf_write got %b required 0 one cycle after DATA", pf_write); end
    repeat (3) cpu_idle();
    cpu_wr(2'd1, 12'h055); exp_data(12'h055, cyc + 2);
    cpu_idle();
    wait_quiet("single", fall);
    d = stream_diff(); checks++;
    if (d != -1) begin failures++; $display("FAIL single stream %s", diff_text(d)); end
    checks++; if (fall != last_wr_cyc + 1) begin failures++; $display("FAIL single busy_fall: got cyc %0d required %0d", fall, last_wr_cyc + 1); end
  endtask

  task automatic test_pointer_wrap();
    int d, fall;
    obs_q.delete(); exp_q.delete();
    cpu_wr(2'd0, 12'h3FF); m_ptr = 12'h3FF;
    cpu_wr(2'd1, 12'h011); exp_data(12'h011, cyc + 2);
    cpu_wr(2'd1, 12'h022); exp_data(12'h022, cyc + 2);
    cpu_idle();
    wait_quiet("wrap", fall);
    d = stream_diff(); checks++;
    if (d != -1) begin failures++; $display("FAIL wrap stream %s", diff_text(d)); end
  endtask

  task automatic test_random();
    int d, fall, op, v;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 9);
      v  = $urandom_range(0, 4095);
      @(negedge i_Clk);
      case (op)
        0, 1: begin drive(2'd0, v); m_ptr = v % 1024; end
        2, 3, 4, 5, 6: begin drive(2'd1, v); exp_data(v, cyc + 2); end
        7: drive(2'd3, v);
        8: begin
          cpu_write   = 1'b1;
          cpu_addr    = {2'($urandom_range(0, 2)), 10'($urandom)};
          cpu_wr_data = 12'(v);
        end
        default: cpu_write = 1'b0;
      endcase
    end
    cpu_idle();
    wait_quiet("random", fall);
    d = stream_diff(); checks++;
    if (d != -1) begin failures++; $display("FAIL random stream %s", diff_text(d)); end
    #1;
    checks++; if (cpu_rd_data !== 12'h000) begin failures++; $display("FAIL random status: got %03h required 000", cpu_rd_data); end
  endtask

  task automatic test_fill_order();
    int d, fall;
    obs_q.delete(); exp_q.delete();
    cpu_wr(2'd0, 12'h010); m_ptr = 12'h010;
    cpu_wr(2'd1, 12'h007); exp_data(12'h007, cyc + 2);
    cpu_wr(2'd2, 12'h03C); exp_fill(cyc + 3, 12'h03C);
    cpu_idle();
    repeat (10) @(negedge i_Clk);
    #1;
    checks++; if (cpu_rd_data !== 12'h080) begin failures++; $display("FAIL fill status_mid: got %03h required 080", cpu_rd_data); end
    wait_quiet("fill", fall);
    d = stream_diff(); checks++;
    if (d != -1) begin failures++; $display("FAIL fill stream %s", diff_text(d)); end
    checks++; if (fall != last_wr_cyc + 1) begin failures++; $display("FAIL fill busy_fall: got cyc %0d required %0d", fall, last_wr_cyc + 1); end
  endtask

  task automatic test_overflow();
    int d, fall, n, base, v;
    int post[$];
    obs_q.delete(); exp_q.delete();
    base = $urandom_range(0, 1023);
    v    = $urandom_range(0, 255);
    cpu_wr(2'd0, base); m_ptr = base;
    cpu_wr(2'd2, v); n = cyc + 1; exp_fill(n + 2, v);
    cpu_idle();
    repeat (5) @(negedge i_Clk);
    for (int k = 0; k < 8; k++) begin
      d = $urandom_range(0, 255);
      cpu_wr(2'd1, d);
      if (k < 4) post.push_back(d);
    end
    cpu_idle(); #1;
    checks++; if (cpu_rd_data !== 12'h0B4) begin failures++; $display("FAIL ovf status_full: got %03h required 0B4", cpu_rd_data); end
    cpu_wr(2'd3, 12'hFFE); cpu_idle(); #1;
    checks++; if (cpu_rd_data !== 12'h0B4) begin failures++; $display("FAIL ovf ctrl_bit0_clear: got %03h required 0B4", cpu_rd_data); end
    cpu_wr(2'd3, 12'h001); cpu_idle(); #1;
    checks++; if (cpu_rd_data !== 12'h094) begin failures++; $display("FAIL ovf clear: got %03h required 094", cpu_rd_data); end
    cpu_wr(2'd2, 12'h0A5); cpu_idle(); #1;
    checks++; if (cpu_rd_data !== 12'h0B4) begin failures++; $display("FAIL ovf fill_during_fill: got %03h required 0B4", cpu_rd_data); end
    cpu_wr(2'd3, 12'h001);
    for (int k = 0; k < 4; k++) exp_data(post[k], n + 2 + 1024 + k);
    m_ptr = (base + 8) % 1024;
    cpu_idle();
    wait_quiet("ovf", fall);
    cpu_wr(2'd1, 12'h0C3); exp_data(12'h0C3, cyc + 2);
    cpu_idle();
    wait_quiet("ovf_tail", fall);
    d = stream_diff(); checks++;
    if (d != -1) begin failures++; $display("FAIL ovf stream %s", diff_text(d)); end
    #1;
    checks++; if (cpu_rd_data !== 12'h000) begin failures++; $display("FAIL ovf status_end: got %03h required 000", cpu_rd_data); end
  endtask

  task automatic test_fill_backlog();
    int d, fall, m, base, a, b, c, v2;
    obs_q.delete(); exp_q.delete();
    base = $urandom_range(0, 1023);
    a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 255);
    v2 = $urandom_range(0, 255);
    cpu_wr(2'd0, base); m_ptr = base;
    cpu_wr(2'd2, 12'h011); exp_fill(cyc + 3, 12'h011);
    cpu_idle();
    repeat (5) @(negedge i_Clk);
    cpu_wr(2'd1, a);
    cpu_wr(2'd1, b);
    cpu_idle();
    wait_write_at(1023, "backlog", m);
    drive(2'd2, v2);
    exp_data(a, m + 1);
    exp_data(b, m + 2);
    exp_fill(m + 4, v2);
    cpu_wr(2'd1, c); exp_data(c, m + 1028);
    cpu_idle();
    wait_quiet("backlog", fall);
    d = stream_diff(); checks++;
    if (d != -1) begin failures++; $display("FAIL backlog stream %s", diff_text(d)); end
  endtask

  task automatic test_reset_mid_fill();
    int d, fall, at;
    cpu_wr(2'd2, 12'h099);
    cpu_idle();
    wait_write_at(500, "midreset", at);
    reset = 1'b1;
    #1;
    checks++; if (pf_write !== 1'b0) begin failures++; $display("FAIL midreset pf_write: got %b required 0", pf_write); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b required 0", busy); end
    checks++; if (cpu_rd_data !== 12'h000) begin failures++; $display("FAIL midreset status: got %03h required 000", cpu_rd_data); end
    @(negedge i_Clk);
    reset = 1'b0;
    obs_q.delete(); exp_q.delete();
    m_ptr = 0;
    cpu_wr(2'd1, 12'h02A); exp_data(12'h02A, cyc + 2);
    cpu_idle();
    wait_quiet("midreset", fall);
    d = stream_diff(); checks++;
    if (d != -1) begin failures++; $display("FAIL midreset stream %s", diff_text(d)); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_pointer_wrap();
    test_random();
    test_fill_order();
    test_overflow();
    test_fill_backlog();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
